// File: rtl/loader_mc_pkg.sv
// Shared definitions for the boot-image loader.
// Holds the FSM state enum, the section-header layout, the pack-mode and
// section-type codes, the error codes, and a lanes-per-word helper.
package loader_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_REQ, S_LEN_WAIT, S_CFG_REQ, S_CFG_WAIT, S_CFG_SHIFT,
    S_HDR_REQ, S_HDR_WAIT, S_DATA_REQ, S_DATA_WAIT, S_UNPACK, S_DONE, S_ERROR
  } state_t;

  // Section header field layout within the low 32 bits of a word.
  localparam int HDR_MODE_LSB = 30, HDR_MODE_W = 2;
  localparam int HDR_TYPE_LSB = 28, HDR_TYPE_W = 2;
  localparam int HDR_IDX_LSB  = 16, HDR_IDX_W  = 12;
  localparam int HDR_CNT_LSB  = 0,  HDR_CNT_W  = 16;

  typedef enum logic [HDR_MODE_W-1:0] {
    PACK_WIDE = 2'd0, PACK_ONE = 2'd1, PACK_TWO = 2'd2, PACK_FOUR = 2'd3
  } pack_t;

  localparam logic [HDR_TYPE_W-1:0] TYPE_END = 2'd3;

  typedef struct packed {
    pack_t                 mode;
    logic [HDR_TYPE_W-1:0] secType;
    logic [HDR_IDX_W-1:0]  index;
    logic [HDR_CNT_W-1:0]  count;
  } hdr_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_INDEX = 2'd1, ERR_OVERFLOW = 2'd2, ERR_TIMEOUT = 2'd3
  } err_t;

  // Instructions produced from one payload word (wide mode emits at most one).
  function automatic logic [2:0] laneCount(input pack_t m);
    case (m)
      PACK_TWO:  return 3'd2;
      PACK_FOUR: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/loader_mc_if.sv
// Loader bus bundle: start request, single-outstanding read port,
// instruction-memory write port, scan-chain port and status.
// master: the loader side. slave: the environment (memory, IMs, top level).
interface loader_mc_if #(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int CHAIN_BITS           = 1,
  parameter int NUM_MEM              = 6,
  parameter int I_WIDE_WIDTH         = 33,
  parameter int IM_ADDR_WIDTH        = 8
);
  logic                            iLoaderWriteReq;
  logic [INTERFACE_WIDTH-1:0]      iLoaderWriteData;
  logic                            oLoaderReadReq;
  logic [INTERFACE_ADDR_WIDTH-1:0] oLoaderReadAddress;
  logic [INTERFACE_WIDTH-1:0]      iLoaderReadData;
  logic                            iLoaderReadDataValid;
  logic [NUM_MEM-1:0]              oIM_WriteEnable;
  logic [IM_ADDR_WIDTH-1:0]        oIM_WriteAddress;
  logic [I_WIDE_WIDTH-1:0]         oIM_WriteData;
  logic                            oConfigEnable;
  logic [CHAIN_BITS-1:0]           oConfigData;
  logic                            oCoreReset;
  logic                            oConfigDone;
  logic                            oBusy;
  logic [1:0]                      oError;

  modport master (
    input  iLoaderWriteReq, iLoaderWriteData, iLoaderReadData, iLoaderReadDataValid,
    output oLoaderReadReq, oLoaderReadAddress, oIM_WriteEnable, oIM_WriteAddress,
           oIM_WriteData, oConfigEnable, oConfigData, oCoreReset, oConfigDone,
           oBusy, oError
  );

  modport slave (
    output iLoaderWriteReq, iLoaderWriteData, iLoaderReadData, iLoaderReadDataValid,
    input  oLoaderReadReq, oLoaderReadAddress, oIM_WriteEnable, oIM_WriteAddress,
           oIM_WriteData, oConfigEnable, oConfigData, oCoreReset, oConfigDone,
           oBusy, oError
  );
endinterface

// File: rtl/loader_mc_unpack.sv
// Payload word buffer and lane counter.
// Ports: iClear (section start), iLoad/iWord (new payload word), iStep (advance
// lane), iMode (pack mode); oInstr (zero-extended instruction), oValid (lane
// carries a write), oLast (final lane of the buffered word).
module loader_mc_unpack
  import loader_mc_pkg::*;
#(
  parameter int IW           = 32,
  parameter int I_WIDTH      = 15,
  parameter int I_WIDE_WIDTH = 33
) (
  input  logic                    iClk,
  input  logic                    iResetN,
  input  logic                    iClear,
  input  logic                    iLoad,
  input  logic                    iStep,
  input  pack_t                   iMode,
  input  logic [IW-1:0]           iWord,
  output logic [I_WIDE_WIDTH-1:0] oInstr,
  output logic                    oValid,
  output logic                    oLast
);
  localparam int WIDE_WORDS = (I_WIDE_WIDTH + IW - 1) / IW;
  localparam int WB   = WIDE_WORDS * IW;
  localparam int WCW  = (WIDE_WORDS > 1) ? $clog2(WIDE_WORDS) : 1;
  localparam int HALF = IW / 2;
  localparam int QUAR = IW / 4;
  localparam int HW   = (HALF < I_WIDTH) ? HALF : I_WIDTH;
  localparam int QW   = (QUAR < I_WIDTH) ? QUAR : I_WIDTH;
  localparam logic [IW-1:0] HMASK = {{(IW-HW){1'b0}}, {HW{1'b1}}};
  localparam logic [IW-1:0] QMASK = {{(IW-QW){1'b0}}, {QW{1'b1}}};

  logic [IW-1:0]           wordBuf;
  logic [I_WIDE_WIDTH-1:0] wideAcc;
  logic [WCW-1:0]          wideCnt;
  logic                    wideReady;
  logic [1:0]              lane;
  logic [IW-1:0]           halfSel, quarSel;

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      wordBuf   <= '0;
      wideAcc   <= '0;
      wideCnt   <= '0;
      wideReady <= 1'b0;
      lane      <= '0;
    end else if (iClear) begin
      wideCnt   <= '0;
      wideReady <= 1'b0;
      lane      <= '0;
    end else if (iLoad) begin
      wordBuf   <= iWord;
      lane      <= '0;
      wideReady <= 1'b0;
      if (iMode == PACK_WIDE) begin
        // Least-significant word arrives first; first word restarts the accumulator.
        wideAcc <= ((wideCnt == '0) ? '0 : wideAcc)
                 | I_WIDE_WIDTH'(WB'(iWord) << (int'(wideCnt) * IW));
        if (wideCnt == WCW'(WIDE_WORDS - 1)) begin
          wideCnt   <= '0;
          wideReady <= 1'b1;
        end else begin
          wideCnt <= wideCnt + 1'b1;
        end
      end
    end else if (iStep) begin
      lane <= lane + 2'd1;
    end
  end

  always_comb begin
    // Lane 0 is the most significant half/quarter.
    halfSel = lane[0] ? wordBuf : (wordBuf >> HALF);
    quarSel = wordBuf >> (QUAR * (3 - int'(lane)));
    case (iMode)
      PACK_WIDE: oInstr = wideAcc;
      PACK_ONE:  oInstr = I_WIDE_WIDTH'(wordBuf[I_WIDTH-1:0]);
      PACK_TWO:  oInstr = I_WIDE_WIDTH'(halfSel & HMASK);
      default:   oInstr = I_WIDE_WIDTH'(quarSel & QMASK);
    endcase
    oValid = (iMode == PACK_WIDE) ? wideReady : 1'b1;
    oLast  = ({1'b0, lane} == (laneCount(iMode) - 3'd1));
  end

endmodule

// File: rtl/loader_mc.sv
// Boot-image loader: reads length word, shifts L config words onto the scan
// chain CHAIN_BITS per cycle, then unpacks instruction sections into NUM_MEM
// instruction memories. Holds the core in reset until a clean load finishes.
// Ports: iClk, iResetN (async, active low), bus (loader_mc_if.master).
// Header fields assume INTERFACE_WIDTH >= 32.
module loader_mc
  import loader_mc_pkg::*;
#(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int CHAIN_BITS           = 1,
  parameter int NUM_MEM              = 6,
  parameter int I_WIDTH              = 15,
  parameter int I_WIDE_WIDTH         = 33,
  parameter int IM_ADDR_WIDTH        = 8,
  parameter int TIMEOUT              = 1024
) (
  input  logic       iClk,
  input  logic       iResetN,
  loader_mc_if.master bus
);
  localparam int IW     = INTERFACE_WIDTH;
  localparam int AW     = INTERFACE_ADDR_WIDTH;
  localparam int SHIFTS = IW / CHAIN_BITS;
  localparam int SCW    = $clog2(SHIFTS);
  localparam int TCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                 state, nextState;
  err_t                   nextErr, pendErr, errReg;
  logic                   configDone;
  logic [AW-1:0]          baseWord, wordCnt;
  logic [IW-1:0]          cfgRemain, shiftReg;
  logic [SCW-1:0]         shiftCnt;
  logic [15:0]            payRemain;
  pack_t                  secMode;
  logic [HDR_IDX_W-1:0]   memIdx;
  logic [IM_ADDR_WIDTH:0] imAddr;     // extra bit flags a write past the top
  logic [TCW-1:0]         timer;

  logic                    isWait, valid, tmoHit, shiftLast, wrFire;
  logic                    unpValid, unpLast;
  logic [I_WIDE_WIDTH-1:0] unpInstr;
  hdr_t                    hdrIn;

  assign valid     = bus.iLoaderReadDataValid;
  assign hdrIn     = hdr_t'(bus.iLoaderReadData[31:0]);
  assign isWait    = state inside {S_LEN_WAIT, S_CFG_WAIT, S_HDR_WAIT, S_DATA_WAIT};
  assign tmoHit    = isWait && !valid && (timer == TCW'(TIMEOUT - 1));
  assign shiftLast = (shiftCnt == SCW'(SHIFTS - 1));
  assign wrFire    = (state == S_UNPACK) && unpValid && !imAddr[IM_ADDR_WIDTH];

  loader_mc_unpack #(.IW(IW), .I_WIDTH(I_WIDTH), .I_WIDE_WIDTH(I_WIDE_WIDTH)) uUnpack (
    .iClk    (iClk),
    .iResetN (iResetN),
    .iClear  ((state == S_HDR_WAIT) && valid),
    .iLoad   ((state == S_DATA_WAIT) && valid),
    .iStep   (state == S_UNPACK),
    .iMode   (secMode),
    .iWord   (bus.iLoaderReadData),
    .oInstr  (unpInstr),
    .oValid  (unpValid),
    .oLast   (unpLast)
  );

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) state <= S_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    nextErr   = ERR_NONE;
    case (state)
      S_IDLE:      if (bus.iLoaderWriteReq) nextState = S_LEN_REQ;
      S_LEN_REQ:   nextState = S_LEN_WAIT;
      S_CFG_REQ:   nextState = S_CFG_WAIT;
      S_HDR_REQ:   nextState = S_HDR_WAIT;
      S_DATA_REQ:  nextState = S_DATA_WAIT;
      S_LEN_WAIT:  if (valid) nextState = (bus.iLoaderReadData == '0) ? S_HDR_REQ : S_CFG_REQ;
      S_CFG_WAIT:  if (valid) nextState = S_CFG_SHIFT;
      S_CFG_SHIFT: if (shiftLast) nextState = (cfgRemain == '0) ? S_HDR_REQ : S_CFG_REQ;
      S_HDR_WAIT: begin
        if (valid) begin
          if (hdrIn.secType == TYPE_END) nextState = S_DONE;
          else if (int'(hdrIn.index) >= NUM_MEM) begin
            nextState = S_ERROR;
            nextErr   = ERR_INDEX;
          end else if (hdrIn.count == '0) nextState = S_HDR_REQ;
          else nextState = S_DATA_REQ;
        end
      end
      S_DATA_WAIT: if (valid) nextState = S_UNPACK;
      S_UNPACK: begin
        if (unpValid && imAddr[IM_ADDR_WIDTH]) begin
          nextState = S_ERROR;
          nextErr   = ERR_OVERFLOW;
        end else if (unpLast) begin
          nextState = (payRemain == '0) ? S_HDR_REQ : S_DATA_REQ;
        end
      end
      S_DONE, S_ERROR: nextState = S_IDLE;
      default:         nextState = S_IDLE;
    endcase
    // Timeout overrides any wait state that saw no data.
    if (tmoHit) begin
      nextState = S_ERROR;
      nextErr   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      baseWord   <= '0;
      wordCnt    <= '0;
      cfgRemain  <= '0;
      shiftReg   <= '0;
      shiftCnt   <= '0;
      payRemain  <= '0;
      secMode    <= PACK_WIDE;
      memIdx     <= '0;
      imAddr     <= '0;
      timer      <= '0;
      pendErr    <= ERR_NONE;
      errReg     <= ERR_NONE;
      configDone <= 1'b0;
    end else begin
      timer <= (isWait && !valid) ? timer + 1'b1 : '0;
      if (isWait && valid) wordCnt <= wordCnt + 1'b1;
      if (nextErr != ERR_NONE) pendErr <= nextErr;
      case (state)
        S_IDLE: begin
          if (bus.iLoaderWriteReq) begin
            baseWord   <= AW'(bus.iLoaderWriteData >> 2);
            wordCnt    <= '0;
            configDone <= 1'b0;
            errReg     <= ERR_NONE;
          end
        end
        S_LEN_WAIT: if (valid) cfgRemain <= bus.iLoaderReadData;
        S_CFG_WAIT: begin
          if (valid) begin
            shiftReg  <= bus.iLoaderReadData;
            shiftCnt  <= '0;
            cfgRemain <= cfgRemain - 1'b1;
          end
        end
        S_CFG_SHIFT: begin
          shiftReg <= shiftReg >> CHAIN_BITS;
          shiftCnt <= shiftCnt + 1'b1;
        end
        S_HDR_WAIT: begin
          if (valid) begin
            secMode   <= hdrIn.mode;
            memIdx    <= hdrIn.index;
            payRemain <= hdrIn.count;
            imAddr    <= '0;
          end
        end
        S_DATA_WAIT: if (valid) payRemain <= payRemain - 1'b1;
        S_UNPACK:    if (wrFire) imAddr <= imAddr + 1'b1;
        S_DONE:      configDone <= 1'b1;
        S_ERROR:     errReg <= pendErr;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.oLoaderReadReq     = state inside {S_LEN_REQ, S_CFG_REQ, S_HDR_REQ, S_DATA_REQ};
    bus.oLoaderReadAddress = (baseWord + wordCnt) << 2;
    bus.oConfigEnable      = (state == S_CFG_SHIFT);
    bus.oConfigData        = (state == S_CFG_SHIFT) ? shiftReg[CHAIN_BITS-1:0] : '0;
    bus.oIM_WriteEnable    = wrFire ? (NUM_MEM'(1) << memIdx) : '0;
    bus.oIM_WriteAddress   = wrFire ? imAddr[IM_ADDR_WIDTH-1:0] : '0;
    bus.oIM_WriteData      = wrFire ? unpInstr : '0;
    bus.oBusy              = (state != S_IDLE);
    bus.oConfigDone        = configDone;
    bus.oError             = errReg;
    bus.oCoreReset         = !iResetN || (state != S_IDLE) || !configDone;
  end

endmodule

// File: tb/tb_loader_mc.sv
module tb_loader_mc;
  localparam int IW = 32, AW = 32, CB = 4, NM = 6, IWD = 15, IWW = 33, IMA = 8, TMO = 1024;

  logic iClk = 1'b0;
  logic iResetN = 1'b0;
  always #5 iClk = ~iClk;

  loader_mc_if #(.INTERFACE_WIDTH(IW), .INTERFACE_ADDR_WIDTH(AW), .CHAIN_BITS(CB),
                 .NUM_MEM(NM), .I_WIDE_WIDTH(IWW), .IM_ADDR_WIDTH(IMA)) bus ();

  loader_mc #(.INTERFACE_WIDTH(IW), .INTERFACE_ADDR_WIDTH(AW), .CHAIN_BITS(CB),
              .NUM_MEM(NM), .I_WIDTH(IWD), .I_WIDE_WIDTH(IWW), .IM_ADDR_WIDTH(IMA),
              .TIMEOUT(TMO)) dut (
    .iClk    (iClk),
    .iResetN (iResetN),
    .bus     (bus)
  );

  logic [31:0]    mem [0:63];
  logic [31:0]    imgQ [$];
  logic [NM-1:0]  wrEnQ [$];
  logic [IMA-1:0] wrAddrQ [$];
  logic [IWW-1:0] wrDataQ [$];
  logic [CB-1:0]  nibQ [$];
  logic [31:0]    firstAddr;
  int             busyCycles;
  bit             hitRst;
  int             checks = 0;
  int             failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    foreach (imgQ[i]) mem[i] = imgQ[i];
  endtask

  // Starts a load at 'base' and serves reads one cycle after each request.
  task automatic run_load(input logic [31:0] base, input int budget, input bit withhold,
                          input bit glitch, input bit rstOnWrite);
    bit          pending = 1'b0;
    bit          gotFirst = 1'b0;
    logic [31:0] pendAddr = '0;
    wrEnQ.delete(); wrAddrQ.delete(); wrDataQ.delete(); nibQ.delete();
    busyCycles = 0;
    hitRst = 1'b0;
    firstAddr = '1;
    bus.iLoaderWriteData = base;
    bus.iLoaderWriteReq = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge iClk); #1;
      bus.iLoaderWriteReq  = glitch && (c == 5);
      bus.iLoaderWriteData = (glitch && c == 5) ? 32'h900 : base;
      bus.iLoaderReadDataValid = 1'b0;
      if (pending && !withhold) begin
        bus.iLoaderReadDataValid = 1'b1;
        bus.iLoaderReadData = mem[6'((pendAddr - base) >> 2)];
      end
      pending  = bus.oLoaderReadReq;
      pendAddr = bus.oLoaderReadAddress;
      if (bus.oLoaderReadReq && !gotFirst) begin
        firstAddr = bus.oLoaderReadAddress;
        gotFirst = 1'b1;
      end
      if (bus.oConfigEnable) nibQ.push_back(bus.oConfigData);
      if (bus.oIM_WriteEnable != '0) begin
        wrEnQ.push_back(bus.oIM_WriteEnable);
        wrAddrQ.push_back(bus.oIM_WriteAddress);
        wrDataQ.push_back(bus.oIM_WriteData);
        if (rstOnWrite) begin
          iResetN = 1'b0;
          hitRst = 1'b1;
          return;
        end
      end
      if (!bus.oBusy) return;
      busyCycles++;
    end
  endtask

  logic [3:0]     expNib [16] = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA,
                                  4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [32:0]    expDatA [4] = '{33'h1111, 33'h2222, 33'h3333, 33'h4444};
  logic [NM-1:0]  expEnB  [6] = '{6'h20, 6'h01, 6'h01, 6'h01, 6'h01, 6'h02};
  logic [IMA-1:0] expAdB  [6] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic [32:0]    expDatB [6] = '{33'h1DEADBEEF, 33'h1, 33'h2, 33'h3, 33'h4, 33'h2BCD};

  initial begin
    bus.iLoaderWriteReq = 1'b0;
    bus.iLoaderWriteData = '0;
    bus.iLoaderReadData = '0;
    bus.iLoaderReadDataValid = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_readReq", 64'(bus.oLoaderReadReq), 64'd0);
    chk("rst_readAddr", 64'(bus.oLoaderReadAddress), 64'd0);
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    chk("rst_done", 64'(bus.oConfigDone), 64'd0);
    chk("rst_error", 64'(bus.oError), 64'd0);
    chk("rst_coreReset", 64'(bus.oCoreReset), 64'd1);
    chk("rst_we", 64'(bus.oIM_WriteEnable), 64'd0);
    chk("rst_cfgEn", 64'(bus.oConfigEnable), 64'd0);
    iResetN = 1'b1;
    #1;
    chk("idle_coreReset", 64'(bus.oCoreReset), 64'd1);

    // Two config words, one mode-2 section into mem 3, end header.
    imgQ = '{32'd2, 32'hA5A5A5A5, 32'h0000FFFF, 32'h80030002,
             32'h11112222, 32'h33334444, 32'h30000000};
    load_img();
    run_load(32'h100, 300, 1'b0, 1'b0, 1'b0);
    chk("A_busy", 64'(bus.oBusy), 64'd0);
    chk("A_firstAddr", 64'(firstAddr), 64'h100);
    chk("A_nibCount", 64'(nibQ.size()), 64'd16);
    for (int i = 0; i < 16 && i < nibQ.size(); i++) chk("A_nib", 64'(nibQ[i]), 64'(expNib[i]));
    chk("A_wrCount", 64'(wrEnQ.size()), 64'd4);
    for (int i = 0; i < 4 && i < wrEnQ.size(); i++) begin
      chk("A_wrEn", 64'(wrEnQ[i]), 64'h08);
      chk("A_wrAddr", 64'(wrAddrQ[i]), 64'(i));
      chk("A_wrData", 64'(wrDataQ[i]), 64'(expDatA[i]));
    end
    chk("A_done", 64'(bus.oConfigDone), 64'd1);
    chk("A_error", 64'(bus.oError), 64'd0);
    chk("A_coreReset", 64'(bus.oCoreReset), 64'd0);

    // No config; wide, four-per-word and one-per-word sections; a stray
    // start request mid-load must be ignored.
    imgQ = '{32'd0, 32'h00050002, 32'hDEADBEEF, 32'h00000001, 32'hC0000001,
             32'h01020304, 32'h40010001, 32'hFFFFABCD, 32'h30000000};
    load_img();
    run_load(32'h200, 300, 1'b0, 1'b1, 1'b0);
    chk("B_busy", 64'(bus.oBusy), 64'd0);
    chk("B_firstAddr", 64'(firstAddr), 64'h200);
    chk("B_nibCount", 64'(nibQ.size()), 64'd0);
    chk("B_wrCount", 64'(wrEnQ.size()), 64'd6);
    for (int i = 0; i < 6 && i < wrEnQ.size(); i++) begin
      chk("B_wrEn", 64'(wrEnQ[i]), 64'(expEnB[i]));
      chk("B_wrAddr", 64'(wrAddrQ[i]), 64'(expAdB[i]));
      chk("B_wrData", 64'(wrDataQ[i]), 64'(expDatB[i]));
    end
    chk("B_done", 64'(bus.oConfigDone), 64'd1);
    chk("B_error", 64'(bus.oError), 64'd0);

    // Index 7 is out of range for 6 memories.
    imgQ = '{32'd0, 32'h00070001, 32'h12345678, 32'h30000000};
    load_img();
    run_load(32'h300, 300, 1'b0, 1'b0, 1'b0);
    chk("C_busy", 64'(bus.oBusy), 64'd0);
    chk("C_error", 64'(bus.oError), 64'd1);
    chk("C_wrCount", 64'(wrEnQ.size()), 64'd0);
    chk("C_done", 64'(bus.oConfigDone), 64'd0);
    chk("C_coreReset", 64'(bus.oCoreReset), 64'd1);

    // Never answer the length read: LEN_REQ + TIMEOUT waits + ERROR.
    run_load(32'h400, TMO + 200, 1'b1, 1'b0, 1'b0);
    chk("D_busy", 64'(bus.oBusy), 64'd0);
    chk("D_error", 64'(bus.oError), 64'd3);
    chk("D_busyCycles", 64'(busyCycles), 64'(TMO + 2));
    chk("D_done", 64'(bus.oConfigDone), 64'd0);

    // Async reset on the first instruction write, then a clean reload.
    imgQ = '{32'd2, 32'hA5A5A5A5, 32'h0000FFFF, 32'h80030002,
             32'h11112222, 32'h33334444, 32'h30000000};
    load_img();
    run_load(32'h100, 300, 1'b0, 1'b0, 1'b1);
    chk("E_hitReset", 64'(hitRst), 64'd1);
    #1;
    chk("E_we", 64'(bus.oIM_WriteEnable), 64'd0);
    chk("E_busy", 64'(bus.oBusy), 64'd0);
    chk("E_readReq", 64'(bus.oLoaderReadReq), 64'd0);
    chk("E_coreReset", 64'(bus.oCoreReset), 64'd1);
    chk("E_error", 64'(bus.oError), 64'd0);
    bus.iLoaderReadDataValid = 1'b0;
    @(negedge iClk);
    iResetN = 1'b1;
    run_load(32'h100, 300, 1'b0, 1'b0, 1'b0);
    chk("E2_busy", 64'(bus.oBusy), 64'd0);
    chk("E2_wrCount", 64'(wrEnQ.size()), 64'd4);
    if (wrDataQ.size() == 4) chk("E2_lastData", 64'(wrDataQ[3]), 64'h4444);
    chk("E2_done", 64'(bus.oConfigDone), 64'd1);
    chk("E2_coreReset", 64'(bus.oCoreReset), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
